// File: rtl/datapath_seq_if.sv
// Control bus of the datapath sequencer: run handshake, program-table write port, datapath controls.
// Optional macro SEQ_LOOP_EN adds the loop_cnt request field.
interface datapath_seq_if #(
   parameter int NREG  = 4,
   parameter int WW    = 3,
   parameter int SW    = 3,
   parameter int SELW  = 2,
   parameter int DEPTH = 8
`ifdef SEQ_LOOP_EN
   , parameter int LCW = 4
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = 1 + NREG + WW + SW + SELW;

   // Handshake: start is taken only at an edge where the sequencer is idle and abort is low;
   // busy is high for the whole CLEAR+RUN stretch, done pulses for one cycle when a run
   // completes, and abort ends a busy run without any done pulse.
   logic            start;
   logic            abort;
   logic            prog_we;
   logic [AW-1:0]   prog_addr;
   logic [CW-1:0]   prog_data;
`ifdef SEQ_LOOP_EN
   logic [LCW-1:0]  loop_cnt;
`endif
   logic            busy;
   logic            done;
   logic            prog_err;
   logic            clr;
   logic [NREG-1:0] ce;
   logic [WW-1:0]   w;
   logic [SW-1:0]   s;
   logic [SELW-1:0] sel;
   logic [1:0]      dbg_state;

`ifdef SEQ_LOOP_EN
   modport master (output start, abort, prog_we, prog_addr, prog_data, loop_cnt,
                   input  busy, done, prog_err, clr, ce, w, s, sel, dbg_state);
   modport slave  (input  start, abort, prog_we, prog_addr, prog_data, loop_cnt,
                   output busy, done, prog_err, clr, ce, w, s, sel, dbg_state);
`else
   modport master (output start, abort, prog_we, prog_addr, prog_data,
                   input  busy, done, prog_err, clr, ce, w, s, sel, dbg_state);
   modport slave  (input  start, abort, prog_we, prog_addr, prog_data,
                   output busy, done, prog_err, clr, ce, w, s, sel, dbg_state);
`endif
endinterface

// File: rtl/datapath_seq.sv
// Table-driven control sequencer for the register-file/ALU/mux datapath.
// Optional macro SEQ_LOOP_EN enables repeated passes over the program (loop_cnt extra passes).
module datapath_seq #(
   parameter int NREG  = 4,
   parameter int WW    = 3,
   parameter int SW    = 3,
   parameter int SELW  = 2,
   parameter int DEPTH = 8
`ifdef SEQ_LOOP_EN
   , parameter int LCW = 4
`endif
) (
   input logic           clk,
   input logic           rst_n,
   datapath_seq_if.slave bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = 1 + NREG + WW + SW + SELW;
   localparam int S_LO  = SELW;
   localparam int W_LO  = SELW + SW;
   localparam int CE_LO = SELW + SW + WW;

   typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

   state_t          state, state_n;
   logic [AW-1:0]   pc, pc_n;
   logic [CW-1:0]   mem [DEPTH];
   logic            cur_last;
   logic            repeat_pass;
   logic            load_step;
   logic            in_run;

   logic            busy_q, busy_n;
   logic            done_q, done_n;
   logic            perr_q, perr_n;
   logic            clr_q, clr_n;
   logic [NREG-1:0] ce_q, ce_n;
   logic [WW-1:0]   w_q, w_n;
   logic [SW-1:0]   s_q, s_n;
   logic [SELW-1:0] sel_q, sel_n;

   assign in_run   = (state == CLEAR) || (state == RUN);
   // The last table slot always terminates a pass, marked or not.
   assign cur_last = mem[pc][CW-1] || (&pc);

`ifdef SEQ_LOOP_EN
   logic [LCW-1:0] pass, lim;
   assign repeat_pass = (pass < lim);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pass <= '0;
         lim  <= '0;
      end else if (state == IDLE && bus.start) begin
         pass <= '0;
         lim  <= bus.loop_cnt;
      end else if (in_run && bus.abort) begin
         pass <= '0;
      end else if (state == RUN && cur_last && repeat_pass) begin
         pass <= pass + LCW'(1);
      end
   end
`else
   assign repeat_pass = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (bus.prog_we && !in_run) mem[bus.prog_addr] <= bus.prog_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         perr_q <= 1'b0;
         clr_q  <= 1'b0;
         ce_q   <= '0;
         w_q    <= '0;
         s_q    <= '0;
         sel_q  <= '0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         busy_q <= busy_n;
         done_q <= done_n;
         perr_q <= perr_n;
         clr_q  <= clr_n;
         ce_q   <= ce_n;
         w_q    <= w_n;
         s_q    <= s_n;
         sel_q  <= sel_n;
      end
   end

   // Outputs are registered, so each branch computes what the next cycle shows.
   always_comb begin
      state_n   = state;
      pc_n      = pc;
      load_step = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      clr_n     = 1'b0;
      ce_n      = '0;
      w_n       = w_q;
      s_n       = s_q;
      sel_n     = sel_q;
      perr_n    = bus.prog_we && in_run;
      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_n = CLEAR;
               pc_n    = '0;
               busy_n  = 1'b1;
               clr_n   = 1'b1;
               w_n     = '0;
               s_n     = '0;
               sel_n   = '0;
            end
         end
         CLEAR: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else begin
               state_n   = RUN;
               pc_n      = '0;
               load_step = 1'b1;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else if (cur_last && !repeat_pass) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               pc_n      = cur_last ? '0 : pc + AW'(1);
               load_step = 1'b1;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (load_step) begin
         busy_n = 1'b1;
         ce_n   = mem[pc_n][CE_LO +: NREG];
         w_n    = mem[pc_n][W_LO +: WW];
         s_n    = mem[pc_n][S_LO +: SW];
         sel_n  = mem[pc_n][0 +: SELW];
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.prog_err  = perr_q;
   assign bus.clr       = clr_q;
   assign bus.ce        = ce_q;
   assign bus.w         = w_q;
   assign bus.s         = s_q;
   assign bus.sel       = sel_q;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: random programs against a cycle-trace reference model.
module tb_datapath_seq;
   localparam int NREG  = 4;
   localparam int WW    = 3;
   localparam int SW    = 3;
   localparam int SELW  = 2;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int CW    = 1 + NREG + WW + SW + SELW;
   localparam int W     = 4 + NREG + WW + SW + SELW;
   localparam int PE_B  = NREG + WW + SW + SELW;
   localparam int CE_LO = SELW + SW + WW;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   datapath_seq_if bus ();
   datapath_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [CW-1:0]   prog_m [DEPTH];
   logic [W-1:0]    exp_q[$];
   bit              abort_q[$];
   logic [WW-1:0]   mw;
   logic [SW-1:0]   ms;
   logic [SELW-1:0] msel;
   int              n_cmp = 0;
   int              n_fail = 0;

   function automatic logic [W-1:0] pk(bit b, bit d, bit c, logic [NREG-1:0] ce_v);
      return {b, d, c, 1'b0, ce_v, mw, ms, msel};
   endfunction

   function automatic logic [W-1:0] observed();
      return {bus.busy, bus.done, bus.clr, bus.prog_err, bus.ce, bus.w, bus.s, bus.sel};
   endfunction

   // Expected per-cycle trace of one run: CLEAR, the steps of each pass, DONE, one IDLE.
   function automatic void build_expected(int abort_at, int lc);
      int rc = 0;
      logic [CW-1:0] wd;
      mw = '0; ms = '0; msel = '0;
      exp_q.push_back(pk(1, 0, 1, '0)); abort_q.push_back(0);
      for (int p = 0; p <= lc; p++) begin
         for (int k = 0; k < DEPTH; k++) begin
            wd   = prog_m[k];
            msel = wd[SELW-1:0];
            ms   = wd[SELW +: SW];
            mw   = wd[SELW+SW +: WW];
            exp_q.push_back(pk(1, 0, 0, wd[CE_LO +: NREG]));
            abort_q.push_back(rc == abort_at);
            if (rc == abort_at) begin
               exp_q.push_back(pk(0, 0, 0, '0)); abort_q.push_back(0);
               return;
            end
            rc++;
            if (wd[CW-1]) break;
         end
      end
      exp_q.push_back(pk(0, 1, 0, '0)); abort_q.push_back(0);
      exp_q.push_back(pk(0, 0, 0, '0)); abort_q.push_back(0);
   endfunction

   // mode 0: no last bits, 1: random last bits, 2: single last bit at step lpos
   task automatic gen_prog(input int mode, input int lpos);
      for (int k = 0; k < DEPTH; k++) begin
         prog_m[k] = CW'($urandom);
         if (mode == 0) prog_m[k][CW-1] = 1'b0;
         else if (mode == 1) prog_m[k][CW-1] = ($urandom_range(0, 3) == 0);
         else prog_m[k][CW-1] = (k == lpos);
      end
   endtask

   task automatic load_prog();
      for (int k = 0; k < DEPTH; k++) begin
         bus.prog_we   = 1'b1;
         bus.prog_addr = AW'(k);
         bus.prog_data = prog_m[k];
         @(negedge clk);
         n_cmp++;
         if (bus.prog_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_prog_err addr %0d: got %b expected 0", k, bus.prog_err);
         end
      end
      bus.prog_we = 1'b0;
   endtask

   task automatic run_check(input string name, input int abort_at, input int lc, input bit noise);
      bit pe_pend = 0;
      int idx = 0;
      int werr_at;
      logic [W-1:0] e, o;
      build_expected(abort_at, lc);
      werr_at = noise ? $urandom_range(0, 1) : -1;
`ifdef SEQ_LOOP_EN
      bus.loop_cnt = 4'(lc);
`endif
      bus.start = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         bus.start = 1'b0; bus.abort = 1'b0; bus.prog_we = 1'b0;
         e = exp_q.pop_front();
         if (pe_pend) e[PE_B] = 1'b1;
         pe_pend = 0;
         o = observed();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, o, e);
         end
         if (abort_q.pop_front()) bus.abort = 1'b1;
         if (noise && e[W-1]) bus.start = 1'($urandom_range(0, 1));
         if (idx == werr_at) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = AW'($urandom_range(0, DEPTH - 1));
            bus.prog_data = CW'($urandom);
            pe_pend = 1;
         end
         idx++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.prog_we = 1'b0;
      bus.prog_addr = '0; bus.prog_data = '0;
`ifdef SEQ_LOOP_EN
      bus.loop_cnt = '0;
`endif
      repeat (3) @(negedge clk);
      n_cmp++;
      if (observed() !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", observed());
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (observed() !== '0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %h expected 0", observed());
      end
   endtask

   task automatic test_spec_program();
      gen_prog(0, 0);
      prog_m[0] = {1'b0, 4'b1111, 3'b000, 3'b010, 2'b00};
      prog_m[1] = {1'b0, 4'b1000, 3'b000, 3'b010, 2'b00};
      prog_m[2] = {1'b0, 4'b0000, 3'b000, 3'b001, 2'b01};
      prog_m[3] = {1'b0, 4'b1100, 3'b100, 3'b001, 2'b01};
      prog_m[4] = {1'b1, 4'b1100, 3'b100, 3'b011, 2'b11};
      load_prog();
      run_check("spec5", -1, 0, 0);
   endtask

   task automatic test_no_last();
      gen_prog(0, 0);
      load_prog();
      run_check("no_last", -1, 0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         gen_prog(1, 0);
         load_prog();
         run_check("random", -1, 0, 1);
      end
   endtask

   task automatic test_abort();
      gen_prog(2, $urandom_range(3, DEPTH - 1));
      load_prog();
      run_check("abort", 2, 0, 0);
      run_check("after_abort", -1, 0, 0);
   endtask

   task automatic test_reset_mid();
      gen_prog(0, 0);
      load_prog();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      n_cmp++;
      if (observed() !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_run: got %h expected 0", observed());
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (observed() !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: got %h expected 0", observed());
      end
      run_check("after_reset", -1, 0, 1);
   endtask

   task automatic test_prog_err();
      gen_prog(2, 4);
      load_prog();
      run_check("prog_err", -1, 0, 1);
      run_check("prog_err_rerun", -1, 0, 0);
   endtask

   task automatic test_back_to_back();
      gen_prog(2, $urandom_range(0, 2));
      load_prog();
      for (int i = 0; i < 3; i++) run_check("back_to_back", -1, 0, 0);
   endtask

`ifdef SEQ_LOOP_EN
   task automatic test_loop();
      gen_prog(2, 2);
      load_prog();
      run_check("loop2", -1, 2, 0);
      gen_prog(1, 0);
      load_prog();
      run_check("loop_rand", -1, $urandom_range(0, 3), 1);
      run_check("loop_abort", 4, 3, 0);
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_spec_program();
      test_no_last();
      test_random();
      test_abort();
      test_reset_mid();
      test_prog_err();
      test_back_to_back();
`ifdef SEQ_LOOP_EN
      test_loop();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
